// File: rtl/cpu_plic_pkg.sv
// cpu_plic_pkg: shared address map, ID type and priority helper for cpu_plic_n
package cpu_plic_pkg;
    localparam logic [23:0] ADDR_PRIO_BASE = 24'h000000;
    localparam logic [23:0] ADDR_PENDING   = 24'h001000;
    localparam logic [23:0] ADDR_MODE      = 24'h001004;
    localparam logic [23:0] ADDR_ENABLE    = 24'h002000;
    localparam logic [23:0] ADDR_THRESHOLD = 24'h200000;
    localparam logic [23:0] ADDR_CLAIM     = 24'h200004;

    typedef logic [4:0] id_t;

    // Keeps only the low 'width' bits of a bus word, i.e. a legal priority value.
    function automatic logic [31:0] prio_t(input int width, input logic [31:0] v);
        return v & ((32'd1 << width) - 32'd1);
    endfunction
endpackage

// File: rtl/cpu_plic_gateway.sv
// cpu_plic_gateway: per-source synchroniser, edge/level detect and in-flight blocking
//   i_clock, i_reset_n : clock, synchronous active-low reset
//   i_line             : raw asynchronous source line
//   i_enable           : source enable bit
//   i_in_flight        : source is currently claimed and not completed
//   i_level            : 1 = level-triggered, 0 = edge-triggered
//   o_set              : one-cycle request to set the pending bit
module cpu_plic_gateway (
    input  logic i_clock,
    input  logic i_reset_n,
    input  logic i_line,
    input  logic i_enable,
    input  logic i_in_flight,
    input  logic i_level,
    output logic o_set
);
    logic [1:0] r_sync;
    logic       r_prev;

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_line};
            r_prev <= r_sync[1];
        end
    end

    // Events arriving while disabled or in flight are dropped, not deferred.
    assign o_set = i_enable && !i_in_flight && (i_level ? r_sync[1] : (r_sync[1] && !r_prev));
endmodule

// File: rtl/cpu_plic_n.sv
// cpu_plic_n: platform-level interrupt controller for one M-mode hart context
//   i_clock, i_reset_n : clock, synchronous active-low reset
//   i_interrupt        : raw source lines, bit k = ID k+1
//   o_interrupt        : external interrupt request to the CPU
//   o_claimed          : a claim is outstanding
//   i_request, i_rw, i_address, i_wdata, o_rdata, o_ready : 24-bit peripheral bus
//   Optional: define CPU_PLIC_LEVEL_EN for the level/edge mode register at 0x001004.
module cpu_plic_n
    import cpu_plic_pkg::*;
#(
    parameter int NUM_SOURCES = 8,
    parameter int PRIO_WIDTH  = 3
) (
    input  logic                   i_clock,
    input  logic                   i_reset_n,
    input  logic [NUM_SOURCES-1:0] i_interrupt,
    output logic                   o_interrupt,
    output logic                   o_claimed,
    input  logic                   i_request,
    input  logic                   i_rw,
    input  logic [23:0]            i_address,
    input  logic [31:0]            i_wdata,
    output logic [31:0]            o_rdata,
    output logic                   o_ready
);
    localparam id_t NS = id_t'(NUM_SOURCES);

    logic [PRIO_WIDTH-1:0]  r_prio [0:31];
    logic [PRIO_WIDTH-1:0]  r_thresh;
    logic [NUM_SOURCES:0]   r_pending;
    logic [NUM_SOURCES:0]   r_enable;
    id_t                    r_claim;
    logic                   r_claimed;
    logic                   r_ready;
    logic [31:0]            r_rdata;
    logic [NUM_SOURCES:0]   w_set;
    logic [NUM_SOURCES:0]   w_level;
    logic [NUM_SOURCES:0]   w_clr;
    logic [PRIO_WIDTH-1:0]  w_best_prio;
    id_t                    w_best;
    id_t                    w_idx;
    logic                   w_go, w_rd, w_wr, w_prio_hit, w_claim_hit, w_do_claim, w_complete;
    logic [31:0]            w_rdata;

`ifdef CPU_PLIC_LEVEL_EN
    logic [NUM_SOURCES:0]   r_mode;
    assign w_level = r_mode;
`else
    assign w_level = '0;
`endif

    assign w_set[0] = 1'b0;
    for (genvar g = 1; g <= NUM_SOURCES; g++) begin : g_gw
        cpu_plic_gateway u_gw (
            .i_clock    (i_clock),
            .i_reset_n  (i_reset_n),
            .i_line     (i_interrupt[g-1]),
            .i_enable   (r_enable[g]),
            .i_in_flight(r_claim == id_t'(g)),
            .i_level    (w_level[g]),
            .o_set      (w_set[g])
        );
    end

    // Ascending scan with strict '>' keeps the lowest ID on a priority tie.
    always_comb begin
        w_best      = '0;
        w_best_prio = '0;
        for (int k = 1; k <= NUM_SOURCES; k++) begin
            if (r_pending[k] && r_enable[k] && r_prio[k] > r_thresh && r_prio[k] > w_best_prio) begin
                w_best      = id_t'(k);
                w_best_prio = r_prio[k];
            end
        end
    end

    assign w_go        = i_request && !r_ready;
    assign w_rd        = w_go && !i_rw;
    assign w_wr        = w_go && i_rw;
    assign w_idx       = i_address[6:2];
    assign w_prio_hit  = (i_address[23:7] == '0) && (i_address[1:0] == 2'b00) && (w_idx != '0) && (w_idx <= NS);
    assign w_claim_hit = (i_address == ADDR_CLAIM);
    // Only one context, so no new claim is granted while one is outstanding.
    assign w_do_claim  = w_rd && w_claim_hit && (r_claim == '0) && (w_best != '0);
    assign w_complete  = w_wr && w_claim_hit && (r_claim != '0) && (i_wdata[4:0] == r_claim);
    assign w_clr       = w_do_claim ? ((NUM_SOURCES+1)'(1) << w_best) : '0;

    always_comb begin
        w_rdata = w_prio_hit                        ? prio_t(PRIO_WIDTH, 32'(r_prio[w_idx])) :
                  (i_address == ADDR_PENDING)       ? 32'(r_pending) :
`ifdef CPU_PLIC_LEVEL_EN
                  (i_address == ADDR_MODE)          ? 32'(r_mode) :
`endif
                  (i_address == ADDR_ENABLE)        ? 32'(r_enable) :
                  (i_address == ADDR_THRESHOLD)     ? 32'(r_thresh) :
                  w_do_claim                        ? 32'(w_best) : 32'd0;
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            for (int k = 0; k < 32; k++) r_prio[k] <= '0;
            r_thresh  <= '0;
            r_pending <= '0;
            r_enable  <= '0;
            r_claim   <= '0;
            r_claimed <= 1'b0;
            r_ready   <= 1'b0;
            r_rdata   <= '0;
`ifdef CPU_PLIC_LEVEL_EN
            r_mode    <= '0;
`endif
        end else begin
            r_ready <= i_request;
            if (w_rd) r_rdata <= w_rdata;
            // Clearing on claim overrides a same-cycle set for the claimed source.
            r_pending <= (r_pending | w_set) & ~w_clr;
            if (w_wr && w_prio_hit) r_prio[w_idx] <= i_wdata[PRIO_WIDTH-1:0];
            if (w_wr && i_address == ADDR_ENABLE) r_enable <= i_wdata[NUM_SOURCES:0] & ~((NUM_SOURCES+1)'(1));
            if (w_wr && i_address == ADDR_THRESHOLD) r_thresh <= i_wdata[PRIO_WIDTH-1:0];
`ifdef CPU_PLIC_LEVEL_EN
            if (w_wr && i_address == ADDR_MODE) r_mode <= i_wdata[NUM_SOURCES:0] & ~((NUM_SOURCES+1)'(1));
`endif
            if (w_do_claim) begin
                r_claim   <= w_best;
                r_claimed <= 1'b1;
            end else if (w_complete) begin
                r_claim   <= '0;
                r_claimed <= 1'b0;
            end
        end
    end

    assign o_interrupt = (w_best != '0) && (r_claim == '0);
    assign o_claimed   = r_claimed;
    assign o_rdata     = r_rdata;
    assign o_ready     = r_ready;
endmodule

// File: tb/tb_cpu_plic_n.sv
// tb_cpu_plic_n: self-checking bench for cpu_plic_n (table vectors, hand sequences, random vs model)
module tb_cpu_plic_n;
    localparam int N  = 8;
    localparam int PW = 3;
    localparam logic [23:0] A_PEND = 24'h001000, A_MODE = 24'h001004, A_EN = 24'h002000;
    localparam logic [23:0] A_THR = 24'h200000, A_CLM = 24'h200004;

    logic          clk = 1'b0;
    logic          i_reset_n = 1'b0;
    logic [N-1:0]  i_interrupt = '0;
    logic          i_request = 1'b0, i_rw = 1'b0;
    logic [23:0]   i_address = '0;
    logic [31:0]   i_wdata = '0;
    logic          o_interrupt, o_claimed, o_ready;
    logic [31:0]   o_rdata;

    always #5 clk = ~clk;

    cpu_plic_n #(.NUM_SOURCES(N), .PRIO_WIDTH(PW)) dut (
        .i_clock(clk), .i_reset_n(i_reset_n), .i_interrupt(i_interrupt),
        .o_interrupt(o_interrupt), .o_claimed(o_claimed),
        .i_request(i_request), .i_rw(i_rw), .i_address(i_address),
        .i_wdata(i_wdata), .o_rdata(o_rdata), .o_ready(o_ready)
    );

    int tests = 0, fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model: the PLIC state as the programmer sees it, plus a log of sampled lines.
    int           m_prio [1:N];
    bit           m_en [1:N], m_pend [1:N], m_mode [1:N];
    int           m_thr, m_claim;
    bit           m_ready;
    logic [31:0]  m_rdata;
    logic [N-1:0] hist [$];
    int           last_rst = 0;

    // A line value sampled at edge t is seen by the gateway 2 edges later; reset erases history.
    function automatic bit line_at(int t, int k);
        if (t < 0 || t <= last_rst) return 1'b0;
        return hist[t][k];
    endfunction

    function automatic int best();
        int b = 0, bp = 0;
        for (int k = 1; k <= N; k++)
            if (m_pend[k] && m_en[k] && m_prio[k] > m_thr && m_prio[k] > bp) begin
                b = k; bp = m_prio[k];
            end
        return b;
    endfunction

    function automatic logic [31:0] bits(input bit v [1:N]);
        logic [31:0] r = '0;
        for (int k = 1; k <= N; k++) r[k] = v[k];
        return r;
    endfunction

    function automatic void model_reset();
        for (int k = 1; k <= N; k++) begin
            m_prio[k] = 0; m_en[k] = 0; m_pend[k] = 0; m_mode[k] = 0;
        end
        m_thr = 0; m_claim = 0; m_ready = 0; m_rdata = '0;
    endfunction

    task automatic tick();
        int t, b, id;
        bit go, clm, s [1:N];
        logic [23:0] a;
        @(posedge clk);
        hist.push_back(i_interrupt);
        t = hist.size() - 1;
        a = i_address;
        if (!i_reset_n) begin
            model_reset();
            last_rst = t;
        end else begin
            b   = best();
            go  = i_request && !m_ready;
            clm = 0;
            for (int k = 1; k <= N; k++) begin
                bit ev;
                ev = (m_mode[k] ? line_at(t-2, k-1) : (line_at(t-2, k-1) && !line_at(t-3, k-1)));
                s[k] = ev && m_en[k] && (m_claim != k);
            end
            if (go && !i_rw) begin
                id = int'(a) / 4;
                if (a[1:0] == 0 && a < 24'h000080 && id >= 1 && id <= N) m_rdata = m_prio[id];
                else if (a == A_PEND) m_rdata = bits(m_pend);
`ifdef CPU_PLIC_LEVEL_EN
                else if (a == A_MODE) m_rdata = bits(m_mode);
`endif
                else if (a == A_EN) m_rdata = bits(m_en);
                else if (a == A_THR) m_rdata = m_thr;
                else if (a == A_CLM && m_claim == 0 && b != 0) begin m_rdata = b; clm = 1; end
                else m_rdata = 0;
            end
            for (int k = 1; k <= N; k++) if (s[k]) m_pend[k] = 1;
            if (clm) begin m_pend[b] = 0; m_claim = b; end
            if (go && i_rw) begin
                id = int'(a) / 4;
                if (a[1:0] == 0 && a < 24'h000080 && id >= 1 && id <= N) m_prio[id] = i_wdata % (1 << PW);
                else if (a == A_EN) for (int k = 1; k <= N; k++) m_en[k] = i_wdata[k];
`ifdef CPU_PLIC_LEVEL_EN
                else if (a == A_MODE) for (int k = 1; k <= N; k++) m_mode[k] = i_wdata[k];
`endif
                else if (a == A_THR) m_thr = i_wdata % (1 << PW);
                else if (a == A_CLM && m_claim != 0 && int'(i_wdata[4:0]) == m_claim) m_claim = 0;
            end
            m_ready = i_request;
        end
        #1;
        chk("ctl{rdy,int,clm}", {29'd0, o_ready, o_interrupt, o_claimed},
            {29'd0, m_ready, (best() != 0 && m_claim == 0), (m_claim != 0)});
        chk("rdata", o_rdata, m_rdata);
    endtask

    task automatic bus(input bit rw, input logic [23:0] a, input logic [31:0] d, input int hold,
                       output logic [31:0] rd);
        i_request = 1; i_rw = rw; i_address = a; i_wdata = d;
        tick();
        rd = o_rdata;
        repeat (hold - 1) tick();
        i_request = 0;
        tick();
    endtask

    typedef struct {
        bit rw; logic [23:0] a; logic [31:0] d; logic [N-1:0] ln; int idle;
        bit chk_rd; logic [31:0] rd; bit ei; bit ec;
    } vec_t;
    vec_t vq [$];

    function automatic void add(bit rw, logic [23:0] a, logic [31:0] d, logic [N-1:0] ln, int idle,
                                bit chk_rd, logic [31:0] rd, bit ei, bit ec);
        vec_t v;
        v.rw = rw; v.a = a; v.d = d; v.ln = ln; v.idle = idle;
        v.chk_rd = chk_rd; v.rd = rd; v.ei = ei; v.ec = ec;
        vq.push_back(v);
    endfunction

    logic [31:0] rd;
    int rdy_cnt;

    initial begin
        model_reset();
        // rw, addr, wdata, lines, idle, chk_rd, rdata, int, claimed
        add(1, A_EN,     32'h0A, 8'h00, 0, 0, 0,  0, 0);
        add(1, 24'h04,   1,      8'h00, 0, 0, 0,  0, 0);
        add(1, 24'h0C,   2,      8'h00, 0, 0, 0,  0, 0);
        add(1, A_THR,    0,      8'h00, 0, 0, 0,  0, 0);
        add(0, A_PEND,   0,      8'h05, 4, 1, 32'h0A, 1, 0);
        add(0, A_CLM,    0,      8'h00, 0, 1, 3,  0, 1);
        add(0, A_CLM,    0,      8'h00, 0, 1, 0,  0, 1);
        add(0, A_PEND,   0,      8'h00, 0, 1, 32'h02, 0, 1);
        add(1, A_CLM,    1,      8'h00, 0, 0, 0,  0, 1);
        add(1, A_CLM,    3,      8'h00, 0, 0, 0,  1, 0);
        add(0, A_CLM,    0,      8'h00, 0, 1, 1,  0, 1);
        add(1, A_CLM,    1,      8'h00, 0, 0, 0,  0, 0);
        add(0, A_CLM,    0,      8'h00, 0, 1, 0,  0, 0);
        add(1, 24'h08,   4,      8'h00, 0, 0, 0,  0, 0);
        add(1, 24'h14,   4,      8'h00, 0, 0, 0,  0, 0);
        add(1, A_EN,     32'h24, 8'h00, 0, 0, 0,  0, 0);
        add(0, A_PEND,   0,      8'h12, 4, 1, 32'h24, 1, 0);
        add(0, A_CLM,    0,      8'h00, 0, 1, 2,  0, 1);
        add(1, A_CLM,    2,      8'h00, 0, 0, 0,  1, 0);
        add(0, A_CLM,    0,      8'h00, 0, 1, 5,  0, 1);
        add(1, A_CLM,    5,      8'h00, 0, 0, 0,  0, 0);
        add(1, A_THR,    4,      8'h00, 0, 0, 0,  0, 0);
        add(0, A_PEND,   0,      8'h02, 4, 1, 32'h04, 0, 0);
        add(1, A_THR,    3,      8'h00, 0, 0, 0,  1, 0);
        add(0, A_CLM,    0,      8'h00, 0, 1, 2,  0, 1);
        add(1, A_CLM,    2,      8'h00, 0, 0, 0,  0, 0);
        add(1, A_THR,    0,      8'h00, 0, 0, 0,  0, 0);
        add(0, 24'h0C,   0,      8'h00, 0, 1, 2,  0, 0);
        add(0, 24'h0D,   0,      8'h00, 0, 1, 0,  0, 0);
        add(0, 24'h24,   0,      8'h00, 0, 1, 0,  0, 0);
        add(0, A_MODE,   0,      8'h00, 0, 1, 0,  0, 0);
        add(0, A_EN,     0,      8'h00, 0, 1, 32'h24, 0, 0);

        i_reset_n = 0;
        tick(); tick();
        chk("reset_ready", {31'd0, o_ready}, 0);
        chk("reset_int", {31'd0, o_interrupt}, 0);
        chk("reset_claimed", {31'd0, o_claimed}, 0);
        chk("reset_rdata", o_rdata, 0);
        i_reset_n = 1;
        tick();

        foreach (vq[i]) begin
            i_interrupt = vq[i].ln;
            repeat (vq[i].idle) tick();
            bus(vq[i].rw, vq[i].a, vq[i].d, 1, rd);
            if (vq[i].chk_rd) chk($sformatf("vec%0d_rdata", i), rd, vq[i].rd);
            chk($sformatf("vec%0d_int", i), {31'd0, o_interrupt}, {31'd0, vq[i].ei});
            chk($sformatf("vec%0d_claimed", i), {31'd0, o_claimed}, {31'd0, vq[i].ec});
        end

        // Source 4 disabled: its edge is dropped, enabling later does not revive it.
        bus(1, 24'h10, 5, 1, rd);
        i_interrupt = 8'h08;
        repeat (5) tick();
        i_interrupt = 8'h00;
        repeat (2) tick();
        bus(1, A_EN, 32'h34, 1, rd);
        bus(0, A_PEND, 0, 1, rd);
        chk("dis_edge_dropped", rd, 0);
        i_interrupt = 8'h08;
        repeat (4) tick();
        i_interrupt = 8'h00;
        bus(0, A_PEND, 0, 1, rd);
        chk("src4_pending", rd, 32'h10);
        // Request held for 4 cycles: one claim, ready high for the 3 cycles after the first.
        i_request = 1; i_rw = 0; i_address = A_CLM;
        rdy_cnt = 0;
        repeat (3) begin tick(); rdy_cnt += int'(o_ready); end
        tick();
        i_request = 0;
        tick();
        chk("held_ready_cycles", rdy_cnt, 3);
        chk("held_claim_rdata", o_rdata, 4);
        chk("held_ready_drop", {31'd0, o_ready}, 0);
        bus(0, A_PEND, 0, 1, rd);
        chk("held_pending_clr", rd, 0);
        bus(1, A_CLM, 4, 1, rd);
        chk("held_complete", {31'd0, o_claimed}, 0);

`ifdef CPU_PLIC_LEVEL_EN
        bus(1, A_EN, 32'h02, 1, rd);
        bus(1, A_MODE, 32'h02, 1, rd);
        i_interrupt = 8'h01;
        repeat (3) tick();
        bus(0, A_CLM, 0, 1, rd);
        chk("lvl_claim", rd, 1);
        bus(1, A_CLM, 1, 1, rd);
        chk("lvl_repend_int", {31'd0, o_interrupt}, 1);
        bus(0, A_PEND, 0, 1, rd);
        chk("lvl_repend", rd, 32'h02);
        i_interrupt = 8'h00;
        repeat (3) tick();
        bus(0, A_CLM, 0, 1, rd);
        chk("lvl_claim2", rd, 1);
        bus(1, A_CLM, 1, 1, rd);
        repeat (2) tick();
        bus(0, A_PEND, 0, 1, rd);
        chk("lvl_low_pending", rd, 0);
        bus(1, A_MODE, 0, 1, rd);
`endif

        // Reset during a claim: the access and any claim are discarded.
        bus(1, A_EN, 32'h02, 1, rd);
        i_interrupt = 8'h01;
        repeat (4) tick();
        i_interrupt = 8'h00;
        i_request = 1; i_rw = 0; i_address = A_CLM;
        tick();
        i_reset_n = 0;
        tick();
        chk("rst_mid_ready", {31'd0, o_ready}, 0);
        chk("rst_mid_claimed", {31'd0, o_claimed}, 0);
        chk("rst_mid_int", {31'd0, o_interrupt}, 0);
        chk("rst_mid_rdata", o_rdata, 0);
        i_request = 0;
        tick();
        i_reset_n = 1;
        tick();

        // Random traffic against the model.
        for (int k = 1; k <= N; k++) bus(1, 24'(4 * k), $urandom_range(0, 7), 1, rd);
        bus(1, A_EN, $urandom, 1, rd);
        for (int n = 0; n < 400; n++) begin
            int op;
            logic [31:0] d;
            logic [23:0] a;
            i_interrupt = i_interrupt ^ (($urandom_range(0, 2) == 0) ? N'(1 << $urandom_range(0, N-1)) : N'(0));
            repeat ($urandom_range(0, 3)) tick();
            op = $urandom_range(0, 9);
            d  = $urandom;
            case (op)
                0: bus(1, 24'(4 * $urandom_range(1, N)), d, 1, rd);
                1: bus(1, A_EN, d, 1, rd);
                2: bus(1, A_THR, $urandom_range(0, 3), 1, rd);
                3, 4: bus(0, A_CLM, 0, $urandom_range(1, 3), rd);
                5: bus(1, A_CLM, ($urandom_range(0, 1) == 1) ? 32'(m_claim) : d, 1, rd);
                6: bus(0, A_PEND, 0, 1, rd);
`ifdef CPU_PLIC_LEVEL_EN
                7: bus(1, A_MODE, d, 1, rd);
`endif
                default: begin
                    a = 24'($urandom_range(0, 40));
                    bus(0, ($urandom_range(0, 1) == 1) ? a : A_EN, 0, 1, rd);
                end
            endcase
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
